// File: rtl/edge_pkg.sv
// Shared constants for the 3x3 window fetcher: pixel/tap geometry, tap offsets
// relative to the window centre, and the fetch FSM encoding.
package edge_pkg;

  localparam int PIX_W     = 8;
  localparam int TAPS      = 9;
  localparam int TAP_IDX_W = 4;

  // Tap k sits at (dx,dy) = (k%3-1, k/3-1), row-major within the window.
  localparam logic signed [1:0] TAP_DX [TAPS] = '{
    -2'sd1, 2'sd0, 2'sd1,
    -2'sd1, 2'sd0, 2'sd1,
    -2'sd1, 2'sd0, 2'sd1
  };
  localparam logic signed [1:0] TAP_DY [TAPS] = '{
    -2'sd1, -2'sd1, -2'sd1,
     2'sd0,  2'sd0,  2'sd0,
     2'sd1,  2'sd1,  2'sd1
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/tap_addr_gen.sv
// Combinational tap locator: given a window centre and tap index, reports
// whether the tap lies inside the image and its byte address.
module tap_addr_gen
  import edge_pkg::*;
#(
  parameter int                IMG_W     = 64,
  parameter int                IMG_H     = 64,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                XW        = $clog2(IMG_W),
  parameter int                YW        = $clog2(IMG_H)
) (
  input  logic [XW-1:0]        cx,
  input  logic [YW-1:0]        cy,
  input  logic [TAP_IDX_W-1:0] k,
  output logic                 in_bounds,
  output logic [ADDR_W-1:0]    addr
);

  int xs;
  int ys;

  // NOTE: every output and temporary gets a default before the branch, so no
  // path through the block leaves a value to be remembered (no latch).
  always_comb begin
    xs        = 0;
    ys        = 0;
    in_bounds = 1'b0;
    addr      = BASE_ADDR;
    // Indices past the last tap are never fetched; report them out of image.
    if (k < TAP_IDX_W'(TAPS)) begin
      xs        = int'(cx) + int'(TAP_DX[k]);
      ys        = int'(cy) + int'(TAP_DY[k]);
      in_bounds = (xs >= 0) && (xs < IMG_W) && (ys >= 0) && (ys < IMG_H);
      addr      = BASE_ADDR + ADDR_W'(ys * IMG_W + xs);
    end
  end

endmodule

// File: rtl/window_fetcher.sv
// Fetches the 3x3 neighbourhood of a pixel over an Avalon-MM pipelined read
// master, zero-filling taps outside the image, then hands it out on a stream.
module window_fetcher
  import edge_pkg::*;
#(
  parameter int                IMG_W     = 64,
  parameter int                IMG_H     = 64,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int               XW        = $clog2(IMG_W),
  localparam int               YW        = $clog2(IMG_H)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [XW-1:0]           x_i,
  input  logic [YW-1:0]           y_i,
  input  logic                    last_i,
  output logic                    ready_o,
  output logic [ADDR_W-1:0]       avm_address_o,
  output logic                    avm_read_o,
  input  logic                    avm_waitrequest_i,
  input  logic [PIX_W-1:0]        avm_readdata_i,
  input  logic                    avm_readdatavalid_i,
  output logic [TAPS*PIX_W-1:0]   win_o,
  output logic                    win_valid_o,
  input  logic                    win_ready_i,
  output logic                    win_last_o,
  output logic                    inc_o
);

  state_e                 state;
  logic [TAP_IDX_W-1:0]   k;
  logic [XW-1:0]          cx;
  logic [YW-1:0]          cy;
  logic                   last_q;
  logic [PIX_W-1:0]       taps [TAPS];

  logic [XW-1:0]          gen_cx;
  logic [YW-1:0]          gen_cy;
  logic [TAP_IDX_W-1:0]   gen_k;
  logic                   gen_in;
  logic [ADDR_W-1:0]      gen_addr;
  logic                   last_tap;

  // The locator looks one tap ahead so the read request and address can be
  // registered on entry to ISSUE; avm_read_o then doubles as "tap in image".
  always_comb begin
    gen_cx = cx;
    gen_cy = cy;
    gen_k  = k + TAP_IDX_W'(1);
    if (state == ST_IDLE) begin
      gen_cx = x_i;
      gen_cy = y_i;
      gen_k  = '0;
    end
  end

  tap_addr_gen #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_tap_addr_gen (
    .cx        (gen_cx),
    .cy        (gen_cy),
    .k         (gen_k),
    .in_bounds (gen_in),
    .addr      (gen_addr)
  );

  assign last_tap = (k == TAP_IDX_W'(TAPS - 1));
  assign inc_o    = win_valid_o & win_ready_i;

  always_comb begin
    for (int i = 0; i < TAPS; i++) win_o[i*PIX_W +: PIX_W] = taps[i];
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the tap registers are reset too because win_o exposes
  // them directly and must read as zero after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      k             <= '0;
      cx            <= '0;
      cy            <= '0;
      last_q        <= 1'b0;
      for (int i = 0; i < TAPS; i++) taps[i] <= '0;
      ready_o       <= 1'b1;
      avm_read_o    <= 1'b0;
      avm_address_o <= '0;
      win_valid_o   <= 1'b0;
      win_last_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i && ready_o) begin
            cx            <= x_i;
            cy            <= y_i;
            last_q        <= last_i;
            k             <= '0;
            ready_o       <= 1'b0;
            avm_read_o    <= gen_in;
            avm_address_o <= gen_addr;
            state         <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (!avm_read_o) begin
            taps[k] <= '0;
            if (last_tap) begin
              win_valid_o <= 1'b1;
              win_last_o  <= last_q;
              state       <= ST_OUT;
            end else begin
              k             <= k + TAP_IDX_W'(1);
              avm_read_o    <= gen_in;
              avm_address_o <= gen_addr;
            end
          end else if (!avm_waitrequest_i) begin
            avm_read_o <= 1'b0;
            state      <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (avm_readdatavalid_i) begin
            taps[k] <= avm_readdata_i;
            if (last_tap) begin
              win_valid_o <= 1'b1;
              win_last_o  <= last_q;
              state       <= ST_OUT;
            end else begin
              k             <= k + TAP_IDX_W'(1);
              avm_read_o    <= gen_in;
              avm_address_o <= gen_addr;
              state         <= ST_ISSUE;
            end
          end
        end

        ST_OUT: begin
          if (win_ready_i) begin
            win_valid_o <= 1'b0;
            win_last_o  <= 1'b0;
            ready_o     <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_fetcher.sv
// Self-checking bench for window_fetcher: directed corner cases plus random
// traffic, compared every cycle against a neighbourhood model of the image.
module tb_window_fetcher;

  localparam int          IMG_W     = 64;
  localparam int          IMG_H     = 64;
  localparam int          ADDR_W    = 32;
  localparam logic [31:0] BASE_ADDR = '0;
  localparam int          XW        = $clog2(IMG_W);
  localparam int          YW        = $clog2(IMG_H);

  logic              clk_i;
  logic              rst_i;
  logic              start_i;
  logic [XW-1:0]     x_i;
  logic [YW-1:0]     y_i;
  logic              last_i;
  logic              ready_o;
  logic [ADDR_W-1:0] avm_address_o;
  logic              avm_read_o;
  logic              avm_waitrequest_i;
  logic [7:0]        avm_readdata_i;
  logic              avm_readdatavalid_i;
  logic [71:0]       win_o;
  logic              win_valid_o;
  logic              win_ready_i;
  logic              win_last_o;
  logic              inc_o;

  window_fetcher #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .start_i             (start_i),
    .x_i                 (x_i),
    .y_i                 (y_i),
    .last_i              (last_i),
    .ready_o             (ready_o),
    .avm_address_o       (avm_address_o),
    .avm_read_o          (avm_read_o),
    .avm_waitrequest_i   (avm_waitrequest_i),
    .avm_readdata_i      (avm_readdata_i),
    .avm_readdatavalid_i (avm_readdatavalid_i),
    .win_o               (win_o),
    .win_valid_o         (win_valid_o),
    .win_ready_i         (win_ready_i),
    .win_last_o          (win_last_o),
    .inc_o               (inc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: awaited event never happened", name);
  endtask

  // Image contents: never zero, so zero-filled taps are distinguishable.
  logic [7:0] mem [IMG_W*IMG_H];

  // Memory slave configuration, set by the stimulus.
  int   wait_lo = 0, wait_hi = 0, dly_lo = 0, dly_hi = 0;
  bit   wait_addr_en = 0;
  logic [31:0] wait_addr = '0;
  bit   stray_en = 0;
  bit   strict = 0;

  // Avalon slave: driven on the falling edge, one response per accepted read.
  bit pend = 0, in_read = 0;
  int pend_addr = 0, pend_delay = 0, wait_left = 0;

  always @(negedge clk_i) begin
    avm_readdatavalid_i = 1'b0;
    avm_readdata_i      = 8'($urandom);
    if (pend) begin
      if (pend_delay == 0) begin
        avm_readdatavalid_i = 1'b1;
        avm_readdata_i      = mem[pend_addr];
        pend                = 1'b0;
      end else begin
        pend_delay--;
      end
    end else if (stray_en && $urandom_range(0, 3) == 0) begin
      avm_readdatavalid_i = 1'b1;
    end
    if (avm_read_o) begin
      if (!in_read) begin
        in_read   = 1'b1;
        wait_left = (wait_addr_en && avm_address_o == wait_addr) ? 3 : int'($urandom_range(wait_hi, wait_lo));
      end
      if (wait_left > 0) begin
        avm_waitrequest_i = 1'b1;
        wait_left--;
      end else begin
        avm_waitrequest_i = 1'b0;
        in_read    = 1'b0;
        pend       = 1'b1;
        pend_addr  = int'(avm_address_o - BASE_ADDR);
        pend_delay = int'($urandom_range(dly_hi, dly_lo));
      end
    end else begin
      avm_waitrequest_i = 1'($urandom_range(0, 1));
      in_read = 1'b0;
    end
  end

  // Reference model: the expected window, read addresses and latency of one
  // request, derived straight from the image geometry.
  logic [71:0] exp_win = '0;
  logic        exp_last = 1'b0;
  int          exp_lat = 0;
  logic [31:0] exp_q [$];

  task automatic build_model(input int x, input int y, input bit last);
    int n_in, xx, yy;
    exp_q.delete();
    exp_win = '0;
    n_in    = 0;
    for (int t = 0; t < 9; t++) begin
      xx = x + (t % 3) - 1;
      yy = y + (t / 3) - 1;
      if (xx >= 0 && xx < IMG_W && yy >= 0 && yy < IMG_H) begin
        exp_q.push_back(BASE_ADDR + 32'(yy * IMG_W + xx));
        exp_win[t*8 +: 8] = mem[yy * IMG_W + xx];
        n_in++;
      end
    end
    exp_last = last;
    exp_lat  = 2 * n_in + (9 - n_in);
  endtask

  // Compare process: sampled on the rising edge, i.e. pre-edge output values.
  int          cyc = 0, acc_cyc = 0, acc_cnt = 0, done_cnt = 0;
  int          obs_lat = 0, txn_inc = 0, valid_cycles = 0, rd_hold_cnt = 0;
  bit          busy = 0, seen_valid = 0, prev_wait = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] obs_addrs [$];
  logic [71:0] obs_win = '0;
  logic        obs_last = 1'b0;

  always @(posedge clk_i) begin
    cyc++;
    if (rst_i) begin
      busy       = 1'b0;
      prev_wait  = 1'b0;
      seen_valid = 1'b0;
      exp_q.delete();
    end else begin
      check("ready_o", ready_o, !busy);
      check("inc_o", inc_o, win_valid_o && win_ready_i);
      if (!busy) begin
        check("read_when_idle", avm_read_o, 1'b0);
        check("valid_when_idle", win_valid_o, 1'b0);
      end
      if (prev_wait) begin
        check("read_held", avm_read_o, 1'b1);
        check("addr_held", avm_address_o, prev_addr);
      end
      if (avm_read_o && wait_addr_en && avm_address_o == wait_addr) rd_hold_cnt++;
      if (avm_read_o && !avm_waitrequest_i) begin
        obs_addrs.push_back(avm_address_o);
        if (exp_q.size() == 0) fail_now("unexpected_read");
        else check("read_addr", avm_address_o, exp_q.pop_front());
      end
      if (win_valid_o) begin
        check("win_o", win_o, exp_win);
        check("win_last_o", win_last_o, exp_last);
        if (!seen_valid) begin
          seen_valid = 1'b1;
          obs_lat    = cyc - acc_cyc - 1;
          check("reads_missing", exp_q.size(), 0);
          if (strict) check("latency", obs_lat, exp_lat);
        end
        valid_cycles++;
      end
      if (inc_o) txn_inc++;
      prev_wait = avm_read_o && avm_waitrequest_i;
      prev_addr = avm_address_o;
      if (win_valid_o && win_ready_i) begin
        busy     = 1'b0;
        obs_win  = win_o;
        obs_last = win_last_o;
        done_cnt++;
      end
      if (start_i && ready_o) begin
        build_model(int'(x_i), int'(y_i), last_i);
        busy         = 1'b1;
        seen_valid   = 1'b0;
        acc_cyc      = cyc;
        acc_cnt++;
        obs_addrs.delete();
        txn_inc      = 0;
        valid_cycles = 0;
        rd_hold_cnt  = 0;
      end
    end
  end

  // One request; rdy_delay < 0 randomises win_ready_i, noisy toggles start_i
  // and the coordinates while the fetcher is busy.
  task automatic run_txn(input int x, input int y, input bit last, input int rdy_delay, input bit noisy);
    int prev_acc, prev_done, vcnt, t;
    @(negedge clk_i);
    prev_acc    = acc_cnt;
    prev_done   = done_cnt;
    start_i     = 1'b1;
    x_i         = XW'(x);
    y_i         = YW'(y);
    last_i      = last;
    win_ready_i = 1'b0;
    t = 0;
    while (acc_cnt == prev_acc && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    start_i = 1'b0;
    if (acc_cnt == prev_acc) begin
      fail_now("start_accept");
      return;
    end
    vcnt = 0;
    t    = 0;
    while (done_cnt == prev_done && t < 400) begin
      if (noisy) begin
        start_i = 1'($urandom_range(0, 1));
        x_i     = XW'($urandom);
        y_i     = YW'($urandom);
        last_i  = 1'($urandom_range(0, 1));
      end
      if (win_valid_o) vcnt++;
      win_ready_i = (rdy_delay < 0) ? 1'($urandom_range(0, 1)) : (vcnt > rdy_delay);
      @(negedge clk_i);
      t++;
    end
    start_i     = 1'b0;
    win_ready_i = 1'b0;
    if (done_cnt == prev_done) fail_now("window_accept");
  endtask

  int          a_mid [9] = '{260, 261, 262, 324, 325, 326, 388, 389, 390};
  int          a_tl  [4] = '{0, 1, 64, 65};
  int          z_tl  [5] = '{0, 1, 2, 3, 6};
  int          z_br  [5] = '{2, 5, 6, 7, 8};
  logic [71:0] win_mid;
  int          rx, ry;

  initial begin
    for (int i = 0; i < IMG_W * IMG_H; i++) mem[i] = 8'(((i * 37 + 11) % 255) + 1);
    rst_i = 1'b1; start_i = 1'b0; x_i = '0; y_i = '0; last_i = 1'b0; win_ready_i = 1'b0;
    avm_waitrequest_i = 1'b0; avm_readdata_i = '0; avm_readdatavalid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", ready_o, 1'b1);
    check("rst_read", avm_read_o, 1'b0);
    check("rst_addr", avm_address_o, 0);
    check("rst_valid", win_valid_o, 1'b0);
    check("rst_last", win_last_o, 1'b0);
    check("rst_inc", inc_o, 1'b0);
    check("rst_win", win_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Interior pixel, no stalls.
    strict = 1;
    run_txn(5, 5, 0, 0, 0);
    check("mid_nreads", obs_addrs.size(), 9);
    for (int i = 0; i < 9 && i < obs_addrs.size(); i++) check("mid_addr", obs_addrs[i], a_mid[i]);
    check("mid_latency", obs_lat, 18);
    check("mid_inc", txn_inc, 1);
    check("mid_last", obs_last, 1'b0);
    win_mid = obs_win;

    // Top-left corner.
    run_txn(0, 0, 0, 0, 0);
    check("tl_nreads", obs_addrs.size(), 4);
    for (int i = 0; i < 4 && i < obs_addrs.size(); i++) check("tl_addr", obs_addrs[i], a_tl[i]);
    check("tl_latency", obs_lat, 13);
    for (int i = 0; i < 5; i++) check("tl_zero_tap", obs_win[z_tl[i]*8 +: 8], 0);
    check("tl_tap4", obs_win[39:32], 12);
    check("tl_tap5", obs_win[47:40], 49);
    check("tl_tap7", obs_win[63:56], 85);
    check("tl_tap8", obs_win[71:64], 122);

    // Bottom-right corner, last pixel of frame.
    run_txn(63, 63, 1, 0, 0);
    for (int i = 0; i < 5; i++) check("br_zero_tap", obs_win[z_br[i]*8 +: 8], 0);
    check("br_last", obs_last, 1'b1);
    check("br_latency", obs_lat, 13);
    strict = 0;

    // Three waitrequest cycles on the centre tap.
    wait_addr_en = 1; wait_addr = 325;
    run_txn(5, 5, 0, 0, 0);
    check("wr_hold_cycles", rd_hold_cnt, 4);
    check("wr_window", obs_win, win_mid);
    wait_addr_en = 0;

    // Consumer stalls five cycles.
    run_txn(10, 20, 0, 5, 0);
    check("bp_valid_cycles", valid_cycles, 6);
    check("bp_inc", txn_inc, 1);

    // Reset while a read is outstanding; the response arrives after reset.
    dly_lo = 2; dly_hi = 2;
    @(negedge clk_i);
    start_i = 1'b1; x_i = XW'(7); y_i = YW'(9); last_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("rw_ready", ready_o, 1'b1);
    check("rw_read", avm_read_o, 1'b0);
    check("rw_addr", avm_address_o, 0);
    check("rw_valid", win_valid_o, 1'b0);
    check("rw_last", win_last_o, 1'b0);
    check("rw_inc", inc_o, 1'b0);
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("rw_stale_win", win_o, 0);
    check("rw_stale_ready", ready_o, 1'b1);
    check("rw_stale_valid", win_valid_o, 1'b0);
    dly_lo = 0; dly_hi = 0;

    // Random traffic with stalls, delayed responses and stray data strobes.
    wait_lo = 0; wait_hi = 2; dly_lo = 0; dly_hi = 2; stray_en = 1;
    for (int n = 0; n < 150; n++) begin
      rx = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? IMG_W - 1 : 0) : int'($urandom_range(0, IMG_W - 1));
      ry = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? IMG_H - 1 : 0) : int'($urandom_range(0, IMG_H - 1));
      run_txn(rx, ry, 1'($urandom_range(0, 1)), -1, 1);
      check("rnd_inc", txn_inc, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    stray_en = 0;
    repeat (3) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
